word_tokenizer: RTL and testbench
=================================

WORD_TOKENIZER -- requirements
Module: word_tokenizer

Interface
REQ-001 Parameter ADDR_WIDTH, default 4, address width of the downstream word SRAM; word capacity MAX_CHARS = 2**ADDR_WIDTH - 1 characters plus a null terminator.
REQ-002 Parameter DATA_WIDTH, default 8, character width.
REQ-003 Parameter DELIM, default 8'h20, word delimiter character.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  input character valid.
REQ-007 in_data  input  DATA_WIDTH  input character.
REQ-008 in_last  input  1  marks the final character of the stream.
REQ-009 in_ready  output  1  block accepts a character this cycle.
REQ-010 wr_en  output  1  write strobe to the word SRAM (cs=1, we=wr_en).
REQ-011 wr_addr  output  ADDR_WIDTH  word SRAM write address.
REQ-012 wr_data  output  DATA_WIDTH  word SRAM write data.
REQ-013 word_valid  output  1  complete null-terminated word in SRAM, ready for the matcher.
REQ-014 word_ack  input  1  matcher finished with the word; buffer may be reused.
REQ-015 word_len  output  ADDR_WIDTH+1  character count of the presented word, excluding terminator.
REQ-016 word_trunc  output  1  presented word exceeded MAX_CHARS and was truncated.
REQ-017 word_count  output  16  number of words presented since reset.

Function
REQ-018 Transfer occurs when in_valid && in_ready; only transfers affect state.
REQ-019 A character is a separator if it equals DELIM or equals zero.
REQ-020 States: IDLE, FILL, DROP, TERM, PRESENT; in_ready = 1 in IDLE/FILL/DROP, 0 in TERM/PRESENT.
REQ-021 IDLE: separator transfer is discarded (leading separators skipped); non-separator transfer writes at address 0, len <= 1, go FILL (or TERM if in_last).
REQ-022 FILL: non-separator with len < MAX_CHARS writes at address len, len <= len+1; go TERM if in_last, else stay.
REQ-023 FILL: non-separator with len == MAX_CHARS is not written, word_trunc flag set, go DROP (or TERM if in_last).
REQ-024 FILL: separator transfer, with or without in_last, writes nothing, go TERM.
REQ-025 DROP: every transfer is discarded; separator or in_last goes TERM.
REQ-026 TERM: one cycle, wr_en=1, wr_addr=len, wr_data=0, go PRESENT.
REQ-027 PRESENT: word_valid=1, word_len=len, word_trunc held; word_count increments by 1 (wraps at 2^16) on PRESENT entry.
REQ-028 PRESENT with word_ack=1: go IDLE next cycle, len and trunc flag cleared, word_valid low next cycle.
REQ-029 word_ack outside PRESENT is ignored.
REQ-030 Character write latency: wr_en asserted the same cycle as the accepting transfer (combinational from the transfer); registered variants are not permitted.
REQ-031 wr_en is 0 in every cycle not described by REQ-021..REQ-026.
REQ-032 in_last with a separator in IDLE returns to IDLE without presenting an empty word.

Reset
REQ-033 rst=1 forces IDLE asynchronously; len=0, word_trunc=0, word_valid=0, wr_en=0, wr_addr=0, wr_data=0, word_count=0; in_ready=1 after release.
REQ-034 Reset mid-word or during PRESENT abandons the word; no terminator is written.

Configuration
REQ-035 With macro WORD_TOKENIZER_CASEFOLD_EN defined, characters 8'h41..8'h5A are written as value+8'h20 (lowercased); separator detection uses the raw character.
REQ-036 Without WORD_TOKENIZER_CASEFOLD_EN, characters are written verbatim.

Verification
REQ-037 Stream " cat dog" (last on 'g') -> writes c,a,t,0 at 0..3, word_valid with word_len=3; after ack, d,o,g,0 at 0..3, word_len=3, word_count=2.
REQ-038 17 chars 'a' then ' ' -> 15 writes at 0..14, terminator at 14+1=15, word_len=15, word_trunc=1; next word has word_trunc=0.
REQ-039 "ab" then hold word_ack=0 for 10 cycles while in_valid=1 -> in_ready=0, no writes, word_valid stays 1.
REQ-040 "CAT " with WORD_TOKENIZER_CASEFOLD_EN -> wr_data 8'h63,8'h61,8'h74,0; without the macro -> 8'h43,8'h41,8'h54,0.
REQ-041 Assert rst after "ca" -> all outputs at reset values, word_count=0; next word "x " presents word_len=1 at address 0.
REQ-042 Stream "  " with in_last on second space -> no writes, word_valid never asserted, word_count=0.

Source files
------------

// File: rtl/word_tokenizer.sv
// Splits a character stream into delimiter-separated words and writes each word into a null-terminated SRAM buffer.
// Optional lowercasing of A..Z on write: define WORD_TOKENIZER_CASEFOLD_EN.
module word_tokenizer #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] DELIM = DATA_WIDTH'(8'h20)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  word_valid,
  input  logic                  word_ack,
  output logic [ADDR_WIDTH:0]   word_len,
  output logic                  word_trunc,
  output logic [15:0]           word_count
);

  localparam int MAX_CHARS = 2**ADDR_WIDTH - 1;
  localparam logic [ADDR_WIDTH:0] MAX_LEN = (ADDR_WIDTH+1)'(MAX_CHARS);

  typedef enum logic [2:0] {IDLE, FILL, DROP, TERM, PRESENT} state_t;

  state_t                state;
  logic [ADDR_WIDTH:0]   len;
  logic                  trunc_q;
  logic                  valid_q;
  logic                  ready_q;
  logic [15:0]           count_q;
  logic                  xfer;
  logic                  is_sep;
  logic [DATA_WIDTH-1:0] char_out;

  assign xfer   = in_valid && ready_q;
  assign is_sep = (in_data == DELIM) || (in_data == '0);

`ifdef WORD_TOKENIZER_CASEFOLD_EN
  always_comb begin
    char_out = in_data;
    if (in_data >= DATA_WIDTH'(8'h41) && in_data <= DATA_WIDTH'(8'h5A))
      char_out = in_data + DATA_WIDTH'(8'h20);
  end
`else
  always_comb char_out = in_data;
`endif

  // Character writes are combinational from the accepting transfer; the
  // terminator write is the whole TERM cycle. Reset forces the bus idle.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    if (!rst) begin
      case (state)
        IDLE: if (xfer && !is_sep) begin
          wr_en   = 1'b1;
          wr_data = char_out;
        end
        FILL: if (xfer && !is_sep && len < MAX_LEN) begin
          wr_en   = 1'b1;
          wr_addr = len[ADDR_WIDTH-1:0];
          wr_data = char_out;
        end
        TERM: begin
          wr_en   = 1'b1;
          wr_addr = len[ADDR_WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      len     <= '0;
      trunc_q <= 1'b0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      count_q <= '0;
    end else begin
      case (state)
        IDLE: if (xfer && !is_sep) begin
          len <= (ADDR_WIDTH+1)'(1);
          if (in_last) begin
            state   <= TERM;
            ready_q <= 1'b0;
          end else begin
            state <= FILL;
          end
        end
        FILL: if (xfer) begin
          if (is_sep) begin
            state   <= TERM;
            ready_q <= 1'b0;
          end else if (len < MAX_LEN) begin
            len <= len + 1'b1;
            if (in_last) begin
              state   <= TERM;
              ready_q <= 1'b0;
            end
          end else begin
            trunc_q <= 1'b1;
            if (in_last) begin
              state   <= TERM;
              ready_q <= 1'b0;
            end else begin
              state <= DROP;
            end
          end
        end
        DROP: if (xfer && (is_sep || in_last)) begin
          state   <= TERM;
          ready_q <= 1'b0;
        end
        TERM: begin
          state   <= PRESENT;
          valid_q <= 1'b1;
          count_q <= count_q + 16'd1;
        end
        PRESENT: if (word_ack) begin
          state   <= IDLE;
          len     <= '0;
          trunc_q <= 1'b0;
          valid_q <= 1'b0;
          ready_q <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready   = ready_q;
  assign word_valid = valid_q;
  assign word_len   = len;
  assign word_trunc = trunc_q;
  assign word_count = count_q;

endmodule

// File: tb/tb_word_tokenizer.sv
// Self-checking bench for word_tokenizer: vector table plus write scoreboard and a few hand-written corner sequences.
module tb_word_tokenizer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_last;
  logic        in_ready;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        word_valid;
  logic        word_ack;
  logic [4:0]  word_len;
  logic        word_trunc;
  logic [15:0] word_count;

  word_tokenizer #(
    .ADDR_WIDTH(4),
    .DATA_WIDTH(8),
    .DELIM(8'h20)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .word_valid(word_valid), .word_ack(word_ack), .word_len(word_len),
    .word_trunc(word_trunc), .word_count(word_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] addr;
    logic [7:0] data;
  } wr_t;

  typedef struct {
    logic [7:0] ch;
    logic       last;
    logic       wr;
    logic [3:0] addr;
    logic       term;
    logic [4:0] wlen;
    logic       trunc;
  } vec_t;

  wr_t  sb[$];
  vec_t vecs[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   exp_count = 0;

  function automatic logic [7:0] fold(input logic [7:0] c);
`ifdef WORD_TOKENIZER_CASEFOLD_EN
    if (c >= 8'h41 && c <= 8'h5A) return c + 8'h20;
`endif
    return c;
  endfunction

  function automatic void add(input logic [7:0] ch, input logic last, input logic wr,
                              input int addr, input logic term, input int wlen, input logic trunc);
    vec_t v;
    v.ch = ch; v.last = last; v.wr = wr; v.addr = addr[3:0];
    v.term = term; v.wlen = wlen[4:0]; v.trunc = trunc;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Every write strobe seen must match the oldest expected write.
  always @(negedge clk) begin
    if (!rst && wr_en) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_write: got addr %0d data %h expected no write", wr_addr, wr_data);
      end else begin
        wr_t e;
        e = sb.pop_front();
        chk("wr_addr", 32'(wr_addr), 32'(e.addr));
        chk("wr_data", 32'(wr_data), 32'(e.data));
      end
    end
  end

  task automatic send(input logic [7:0] ch, input logic last);
    in_valid = 1'b1; in_data = ch; in_last = last;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
  endtask

  task automatic finish_word(input int exp_len, input logic exp_trunc);
    int unsigned n;
    n = 0;
    exp_count++;
    @(negedge clk);
    while (!word_valid && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("word_valid", 32'(word_valid), 32'd1);
    if (word_valid) begin
      chk("word_len", 32'(word_len), 32'(exp_len));
      chk("word_trunc", 32'(word_trunc), 32'(exp_trunc));
      chk("word_count", 32'(word_count), 32'(exp_count[15:0]));
      chk("ready_in_present", 32'(in_ready), 32'd0);
    end
    chk("sb_drained", 32'(sb.size()), 32'd0);
    word_ack = 1'b1;
    @(posedge clk); #1;
    word_ack = 1'b0;
    chk("valid_cleared", 32'(word_valid), 32'd0);
    chk("ready_after_ack", 32'(in_ready), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; word_ack = 1'b0;

    // " cat dog" ending on 'g'
    add(" ", 0, 0, 0, 0, 0, 0);
    add("c", 0, 1, 0, 0, 0, 0);
    add("a", 0, 1, 1, 0, 0, 0);
    add("t", 0, 1, 2, 0, 0, 0);
    add(" ", 0, 0, 0, 1, 3, 0);
    add("d", 0, 1, 0, 0, 0, 0);
    add("o", 0, 1, 1, 0, 0, 0);
    add("g", 1, 1, 2, 1, 3, 0);
    // 17 x 'a' then ' ': truncated at 15
    for (int i = 0; i < 17; i++) add("a", 0, (i < 15), i, 0, 0, 0);
    add(" ", 0, 0, 0, 1, 15, 1);
    add("h", 0, 1, 0, 0, 0, 0);
    add("i", 0, 1, 1, 0, 0, 0);
    add(" ", 0, 0, 0, 1, 2, 0);
    // exactly MAX_CHARS fits without truncation
    for (int i = 0; i < 15; i++) add("b", 0, 1, i, 0, 0, 0);
    add(" ", 0, 0, 0, 1, 15, 0);
    // overflow character carrying in_last goes straight to terminate
    for (int i = 0; i < 16; i++) add("b", (i == 15), (i < 15), i, (i == 15), 15, (i == 15));
    add("C", 0, 1, 0, 0, 0, 0);
    add("A", 0, 1, 1, 0, 0, 0);
    add("T", 0, 1, 2, 0, 0, 0);
    add(" ", 0, 0, 0, 1, 3, 0);
    add("x", 0, 1, 0, 0, 0, 0);
    add(" ", 1, 0, 0, 1, 1, 0);
    add("q", 0, 1, 0, 0, 0, 0);
    add(8'h00, 0, 0, 0, 1, 1, 0);
    add(" ", 0, 0, 0, 0, 0, 0);
    add(" ", 1, 0, 0, 0, 0, 0);

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    chk("rst_word_valid", 32'(word_valid), 32'd0);
    chk("rst_word_len", 32'(word_len), 32'd0);
    chk("rst_word_trunc", 32'(word_trunc), 32'd0);
    chk("rst_word_count", 32'(word_count), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_rst", 32'(in_ready), 32'd1);

    foreach (vecs[i]) begin
      chk($sformatf("in_ready_v%0d", i), 32'(in_ready), 32'd1);
      if (vecs[i].wr) sb.push_back('{vecs[i].addr, fold(vecs[i].ch)});
      if (vecs[i].term) sb.push_back('{vecs[i].wlen[3:0], 8'h00});
      send(vecs[i].ch, vecs[i].last);
      if (vecs[i].term) finish_word(int'(vecs[i].wlen), vecs[i].trunc);
    end
    // separators-only stream: nothing presented
    repeat (3) begin
      @(negedge clk);
      chk("no_empty_word", 32'(word_valid), 32'd0);
    end
    chk("count_after_seps", 32'(word_count), 32'(exp_count[15:0]));

    // explicit case folding expectations on "CAT "
`ifdef WORD_TOKENIZER_CASEFOLD_EN
    sb.push_back('{4'd0, 8'h63}); sb.push_back('{4'd1, 8'h61}); sb.push_back('{4'd2, 8'h74});
`else
    sb.push_back('{4'd0, 8'h43}); sb.push_back('{4'd1, 8'h41}); sb.push_back('{4'd2, 8'h54});
`endif
    sb.push_back('{4'd3, 8'h00});
    @(posedge clk); #1;
    send("C", 0); send("A", 0); send("T", 0); send(" ", 0);
    finish_word(3, 0);

    // ack ignored outside PRESENT
    word_ack = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    word_ack = 1'b0;
    chk("ack_idle_ready", 32'(in_ready), 32'd1);
    chk("ack_idle_valid", 32'(word_valid), 32'd0);
    chk("ack_idle_count", 32'(word_count), 32'(exp_count[15:0]));

    // backpressure while the word is held
    sb.push_back('{4'd0, "a"}); sb.push_back('{4'd1, "b"}); sb.push_back('{4'd2, 8'h00});
    send("a", 0); send("b", 1);
    in_valid = 1'b1; in_data = "q";
    @(negedge clk);
    repeat (10) begin
      @(negedge clk);
      chk("hold_ready", 32'(in_ready), 32'd0);
      chk("hold_valid", 32'(word_valid), 32'd1);
      chk("hold_wr_en", 32'(wr_en), 32'd0);
    end
    in_valid = 1'b0; in_data = 8'h00;
    finish_word(2, 0);

    // reset mid-word abandons it
    sb.push_back('{4'd0, "c"}); sb.push_back('{4'd1, "a"});
    send("c", 0); send("a", 0);
    in_valid = 1'b1; in_data = "z";
    rst = 1'b1;
    #1;
    chk("mid_rst_wr_en", 32'(wr_en), 32'd0);
    chk("mid_rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("mid_rst_wr_data", 32'(wr_data), 32'd0);
    chk("mid_rst_len", 32'(word_len), 32'd0);
    chk("mid_rst_count", 32'(word_count), 32'd0);
    chk("mid_rst_valid", 32'(word_valid), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = 8'h00;
    rst = 1'b0;
    exp_count = 0;
    chk("mid_rst_sb", 32'(sb.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("mid_rst_ready", 32'(in_ready), 32'd1);
    sb.push_back('{4'd0, "x"}); sb.push_back('{4'd1, 8'h00});
    send("x", 0); send(" ", 0);
    finish_word(1, 0);

    chk("final_sb", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
